// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared types and constants for the RTC multiplexed-bus burst engine.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    DATA,
    RECOV,
    FIN
  } state_e;

  // Strobe vectors, bit order {ad, cs, rd, wr}, all active-low.
  localparam logic [3:0] STROBE_IDLE  = 4'b1111;
  localparam logic [3:0] STROBE_ADDR  = 4'b0010;
  localparam logic [3:0] STROBE_WRITE = 4'b1010;
  localparam logic [3:0] STROBE_READ  = 4'b1001;

  // RTC register map used by the init / hour / date / chrono sequences.
  localparam logic [7:0] RTC_REG_SEC    = 8'h00;
  localparam logic [7:0] RTC_REG_MIN    = 8'h02;
  localparam logic [7:0] RTC_REG_HOUR   = 8'h04;
  localparam logic [7:0] RTC_REG_DAY    = 8'h07;
  localparam logic [7:0] RTC_REG_MONTH  = 8'h08;
  localparam logic [7:0] RTC_REG_YEAR   = 8'h09;
  localparam logic [7:0] RTC_REG_A      = 8'h0A;
  localparam logic [7:0] RTC_REG_B      = 8'h0B;
  localparam logic [7:0] RTC_REG_C      = 8'h0C;
  localparam logic [7:0] RTC_REG_CHRONO = 8'h0E;

  // Width of a length field able to hold 0..nreg.
  function automatic int len_width(input int nreg);
    return $clog2(nreg + 1);
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Request/response and RTC pin bundle of the burst engine.
interface rtc_bus_sequencer_if #(
  parameter int DW   = 8,
  parameter int NREG = 16,
  parameter int LW   = rtc_bus_pkg::len_width(NREG)
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [DW-1:0]        req_addr;
  logic [LW-1:0]        req_len;
  logic [NREG*DW-1:0]   req_wdata;
  logic                 abort;
  logic [NREG*DW-1:0]   rd_data;
  logic                 done;
  logic                 err;
  logic                 ad;
  logic                 cs;
  logic                 rd;
  logic                 wr;
  logic [DW-1:0]        ad_out;
  logic                 ad_oe;
  logic [DW-1:0]        ad_in;

  // Control side plus the RTC pins feeding back into the engine.
  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, abort, ad_in,
    input  req_ready, rd_data, done, err, ad, cs, rd, wr, ad_out, ad_oe
  );

  // The burst engine itself.
  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, abort, ad_in,
    output req_ready, rd_data, done, err, ad, cs, rd, wr, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// Bus phase timer: reloads to T_PHASE-1, counts down, flags the last cycle.
module rtc_phase_timer #(
  parameter int T_PHASE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic last_o
);
  localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

  logic [CW-1:0] cnt_q;

  // Down-counter; with T_PHASE=1 it sits at zero so every cycle is last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt_q <= CW'(T_PHASE - 1);
    else if (load_i)          cnt_q <= CW'(T_PHASE - 1);
    else if (cnt_q != '0)     cnt_q <= cnt_q - 1'b1;
  end

  assign last_o = (cnt_q == '0);
endmodule

// File: rtl/rtc_bus_sequencer.sv
// Burst engine for the RTC multiplexed AD/CS/RD/WR bus: 1..NREG consecutive
// registers per request, ADDR/GAP/DATA/RECOV phases of T_PHASE cycles each.
module rtc_bus_sequencer import rtc_bus_pkg::*; #(
  parameter int DW      = 8,
  parameter int NREG    = 16,
  parameter int T_PHASE = 4,
  parameter int LW      = len_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  rtc_bus_sequencer_if.slave  bus
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  state_e                     state_q, state_d;
  logic [LW-1:0]              idx_q, idx_d, len_q;
  logic [IW-1:0]              sel_q, sel_d;
  logic                       write_q, write_n;
  logic [DW-1:0]              addr_q, addr_n;
  logic [NREG-1:0][DW-1:0]    wdata_q, wdata_n, rd_data_q;
  logic                       fail_q, fail_d;
  logic [3:0]                 strb_q, strb_d;
  logic [DW-1:0]              ad_out_q, ad_out_d;
  logic                       ad_oe_q, ad_oe_d;
  logic                       req_ready_q, done_q, err_q;
  logic                       accept, capture, abort_bus, tmr_load, tmr_last;

  assign accept    = bus.req_valid && req_ready_q;
  assign abort_bus = bus.abort && (state_q inside {ADDR, GAP, DATA});
  // Reload on every phase boundary; holding it in IDLE/FIN preloads ADDR.
  assign tmr_load  = (state_q == IDLE) || (state_q == FIN) || tmr_last || abort_bus;

  assign write_n = accept ? bus.req_write : write_q;
  assign addr_n  = accept ? bus.req_addr  : addr_q;
  assign wdata_n = accept ? bus.req_wdata : wdata_q;
  assign sel_q   = idx_q[IW-1:0];
  assign sel_d   = idx_d[IW-1:0];

  rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (tmr_load),
    .last_o (tmr_last)
  );

  // Next-state: phase sequencing, register index, abort / length-error flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        idx_d = '0;
        if (bus.req_len == '0 || bus.req_len > LW'(NREG)) begin
          state_d = FIN;
          fail_d  = 1'b1;
        end else begin
          state_d = ADDR;
          fail_d  = 1'b0;
        end
      end
      ADDR: begin
        if (bus.abort) begin state_d = RECOV; fail_d = 1'b1; end
        else if (tmr_last) state_d = GAP;
      end
      GAP: begin
        if (bus.abort) begin state_d = RECOV; fail_d = 1'b1; end
        else if (tmr_last) state_d = DATA;
      end
      DATA: begin
        if (bus.abort) begin state_d = RECOV; fail_d = 1'b1; end
        else if (tmr_last) begin
          state_d = RECOV;
          capture = !write_q;
        end
      end
      RECOV: begin
        // Abort here only marks the burst; RECOV still runs to its end.
        if (bus.abort) fail_d = 1'b1;
        if (tmr_last) begin
          if (fail_d || idx_q == len_q - 1'b1) state_d = FIN;
          else begin
            idx_d   = idx_q + 1'b1;
            state_d = ADDR;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the state being entered, so the pins register with it.
  always_comb begin
    strb_d   = STROBE_IDLE;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    case (state_d)
      ADDR: begin
        strb_d   = STROBE_ADDR;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_n + DW'(idx_d);
      end
      DATA: begin
        if (write_n) begin
          strb_d   = STROBE_WRITE;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_n[sel_d];
        end else begin
          strb_d   = STROBE_READ;
        end
      end
      default: ;
    endcase
  end

  // FSM state, request latch, read capture and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      fail_q      <= 1'b0;
      strb_q      <= STROBE_IDLE;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fail_q      <= fail_d;
      write_q     <= write_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      if (accept)  len_q <= bus.req_len;
      if (capture) rd_data_q[sel_q] <= bus.ad_in;
      strb_q      <= strb_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      req_ready_q <= (state_d == IDLE);
      done_q      <= (state_d == FIN);
      err_q       <= (state_d == FIN) && fail_d;
    end
  end

  assign bus.ad        = strb_q[3];
  assign bus.cs        = strb_q[2];
  assign bus.rd        = strb_q[1];
  assign bus.wr        = strb_q[0];
  assign bus.ad_out    = ad_out_q;
  assign bus.ad_oe     = ad_oe_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.req_ready = req_ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer (DW=8, NREG=16, T_PHASE=4).
module tb_rtc_bus_sequencer;
  import rtc_bus_pkg::*;

  localparam int NREG  = 16;
  localparam int TP    = 4;
  localparam int LW    = 5;
  localparam int LIMIT = 4 * TP * NREG + 8;

  typedef struct {
    logic            wr;
    logic [7:0]      addr;
    int              len;
    logic [3:0][7:0] dat;       // write data, or what the RTC returns on reads
    logic [3:0][7:0] exp_addr;  // address expected in each ADDR phase
    logic            err;
    int              done_cyc;  // cycle of done, cycle 1 = first after accept edge
    int              abort_cyc; // 0 = no abort; else abort sampled end of that cycle
    logic            abt_acc;   // abort raised together with req_valid
    int              ncap;      // rd_data entries expected to be captured
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [NREG*8-1:0] img;
  vec_t vecs [8];

  always #5 clk = ~clk;

  rtc_bus_sequencer_if #(.DW(8), .NREG(NREG), .LW(LW)) bus ();
  rtc_bus_sequencer #(.DW(8), .NREG(NREG), .T_PHASE(TP), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] addr, input int len,
                              input logic [31:0] dat, input logic [31:0] ea, input logic err,
                              input int done_cyc, input int abort_cyc, input logic abt_acc,
                              input int ncap);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.dat = dat; v.exp_addr = ea; v.err = err;
    v.done_cyc = done_cyc; v.abort_cyc = abort_cyc; v.abt_acc = abt_acc; v.ncap = ncap;
    return v;
  endfunction

  // Expected {ad,cs,rd,wr} and ad_oe in cycle n of a request.
  function automatic void exp_at(input vec_t v, input int n, input bit bad,
                                 output logic [3:0] s, output logic oe);
    int ph;
    s = 4'b1111; oe = 1'b0;
    if (bad || n > 4 * TP * v.len || (v.abort_cyc != 0 && n > v.abort_cyc)) return;
    ph = ((n - 1) % (4 * TP)) / TP;
    case (ph)
      0: begin s = 4'b0010; oe = 1'b1; end
      2: if (v.wr) begin s = 4'b1010; oe = 1'b1; end else s = 4'b1001;
      default: ;
    endcase
  endfunction

  // Called at a negedge with the engine idle; returns one cycle after done.
  task automatic run_vec(input vec_t v, input int k);
    int bad_cyc, done_at, r, ph, pin;
    logic err_at;
    logic [3:0] s;
    logic oe;
    bit bad;
    bad = (v.len == 0 || v.len > NREG);
    chk($sformatf("v%0d ready", k), {127'd0, bus.req_ready}, 128'd1);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_len   = LW'(v.len);
    bus.req_wdata = '0;
    for (int i = 0; i < 4; i++) bus.req_wdata[i*8 +: 8] = v.dat[i];
    bus.abort = v.abt_acc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bad_cyc = 0; done_at = 0; err_at = 1'bx;
    for (int n = 1; n <= LIMIT; n++) begin
      exp_at(v, n, bad, s, oe);
      r   = (n - 1) / (4 * TP);
      ph  = ((n - 1) % (4 * TP)) / TP;
      pin = (n - 1) % TP;
      if ({bus.ad, bus.cs, bus.rd, bus.wr} !== s || bus.ad_oe !== oe ||
          bus.req_ready !== 1'b0 || bus.done !== (n == v.done_cyc)) bad_cyc++;
      if (!bad && r < v.len && pin == 0 && (v.abort_cyc == 0 || n <= v.abort_cyc)) begin
        if (ph == 0) chk($sformatf("v%0d addr%0d", k, r), {120'd0, bus.ad_out}, {120'd0, v.exp_addr[r]});
        if (ph == 2 && v.wr) chk($sformatf("v%0d wdata%0d", k, r), {120'd0, bus.ad_out}, {120'd0, v.dat[r]});
      end
      bus.ad_in = (!bad && !v.wr && ph == 2 && r < 4) ? v.dat[r] : 8'hFF;
      bus.abort = (v.abort_cyc != 0 && n == v.abort_cyc);
      if (bus.done === 1'b1) begin
        done_at = n;
        err_at  = bus.err;
        break;
      end
      @(negedge clk);
    end
    bus.abort = 1'b0;
    bus.ad_in = 8'hFF;
    chk($sformatf("v%0d timeline", k), 128'(bad_cyc), 128'd0);
    chk($sformatf("v%0d done_cycle", k), 128'(done_at), 128'(v.done_cyc));
    chk($sformatf("v%0d err", k), {127'd0, err_at}, {127'd0, v.err});
    if (!v.wr && !bad)
      for (int i = 0; i < v.ncap; i++) img[i*8 +: 8] = v.dat[i];
    chk($sformatf("v%0d rd_data", k), bus.rd_data, img);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1'b1, 8'h21, 3, {8'h00, 8'h56, 8'h34, 8'h12}, {8'h00, 8'h23, 8'h22, 8'h21}, 1'b0, 49, 0, 1'b0, 0);
    vecs[1] = mk(1'b0, 8'h64, 2, {8'h00, 8'h00, 8'h07, 8'h59}, {8'h00, 8'h00, 8'h65, 8'h64}, 1'b0, 33, 0, 1'b0, 2);
    vecs[2] = mk(1'b1, 8'hFF, 2, {8'h00, 8'h00, 8'h55, 8'hAA}, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b0, 33, 0, 1'b0, 0);
    // Length errors: no bus phase, done in the cycle right after accept.
    vecs[3] = mk(1'b1, 8'h40, 0, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0, 0);
    vecs[4] = mk(1'b0, 8'h40, NREG + 1, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0, 0);
    // Abort together with the request in IDLE is ignored.
    vecs[5] = mk(1'b0, 8'h10, 1, {24'h0, 8'h3C}, {24'h0, 8'h10}, 1'b0, 17, 0, 1'b1, 1);
    // Abort in cycle 26 = second cycle of register 1 DATA; 4 RECOV, done at 31.
    vecs[6] = mk(1'b0, 8'h30, 4, {8'hA4, 8'hA3, 8'hA2, 8'hA1}, {8'h33, 8'h32, 8'h31, 8'h30}, 1'b1, 31, 26, 1'b0, 1);
    // Issued on the cycle right after the aborted burst's done.
    vecs[7] = mk(1'b1, RTC_REG_B, 1, {24'h0, 8'h86}, {24'h0, RTC_REG_B}, 1'b0, 17, 0, 1'b0, 0);

    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.req_wdata = '0; bus.abort = 1'b0; bus.ad_in = 8'hFF;
    img = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst strobes", {124'd0, bus.ad, bus.cs, bus.rd, bus.wr}, 128'hF);
    chk("rst oe/out", {119'd0, bus.ad_oe, bus.ad_out}, 128'd0);
    chk("rst ready/done/err", {125'd0, bus.req_ready, bus.done, bus.err}, 128'b100);
    chk("rst rd_data", bus.rd_data, 128'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) run_vec(vecs[k], k);

    // Reset in the middle of a read burst: pins idle before any clock edge.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h50; bus.req_len = LW'(2);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid cs active", {127'd0, bus.cs}, 128'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid rst strobes", {123'd0, bus.ad, bus.cs, bus.rd, bus.wr, bus.ad_oe}, 128'h1E);
    chk("mid rst rd_data", bus.rd_data, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post rst ready/done", {126'd0, bus.req_ready, bus.done}, 128'b10);
    chk("post rst rd_data", bus.rd_data, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
